// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data memory: access-size codes and default widths.
package mem_pkg;

    localparam int NB_WIDTH_DEF = 32;
    localparam int NB_ADDR_DEF  = 9;
    localparam int NB_DATA_DEF  = 8;

    localparam logic [1:0] BHW_BYTE = 2'b00;
    localparam logic [1:0] BHW_HALF = 2'b01;
    localparam logic [1:0] BHW_WORD = 2'b11;

    localparam int BHW_UNSIGNED_BIT = 2;

    // Code 2'b10 is treated as a word, so any size with bit1 set needs 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
        return ((size == BHW_HALF) && a_lo[0]) || (size[1] && (a_lo != 2'b00));
    endfunction

endpackage

// File: rtl/load_extend.sv
// Size select plus sign/zero extension of a little-endian assembled load word.
module load_extend
    import mem_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF,
    parameter int NB_DATA  = NB_DATA_DEF
) (
    input  logic [NB_WIDTH-1:0] raw_word,
    input  logic [2:0]          bhw,
    output logic [NB_WIDTH-1:0] ext_word
);

    logic sgn_b;
    logic sgn_h;

    always_comb begin
        sgn_b = raw_word[NB_DATA-1]   & ~bhw[BHW_UNSIGNED_BIT];
        sgn_h = raw_word[2*NB_DATA-1] & ~bhw[BHW_UNSIGNED_BIT];
        case (bhw[1:0])
            BHW_BYTE: ext_word = {{(NB_WIDTH-NB_DATA){sgn_b}}, raw_word[NB_DATA-1:0]};
            BHW_HALF: ext_word = {{(NB_WIDTH-2*NB_DATA){sgn_h}}, raw_word[2*NB_DATA-1:0]};
            default:  ext_word = raw_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM-stage byte-addressable little-endian data memory with registered, extended loads.
// Optional MEM_ALIGN_CHECK_EN adds o_misaligned and suppresses misaligned accesses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int NB_WIDTH = NB_WIDTH_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int NB_DATA  = NB_DATA_DEF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [NB_WIDTH-1:0] i_mem_addr,
    input  logic [NB_WIDTH-1:0] i_mem_data,
    input  logic                i_mem_read_CU,
    input  logic                i_mem_write_CU,
    input  logic [2:0]          i_BHW_CU,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                o_misaligned,
`endif
    output logic [NB_WIDTH-1:0] o_read_data
);

    localparam int NB_BYTES = NB_WIDTH / NB_DATA;
    localparam int DEPTH    = 2 ** NB_ADDR;

    logic [NB_DATA-1:0]  mem [DEPTH];
    logic [NB_ADDR-1:0]  addr [NB_BYTES];
    logic [NB_BYTES-1:0] byte_we;
    logic [NB_WIDTH-1:0] raw_word;
    logic [NB_WIDTH-1:0] ext_word;
    logic                misaligned;
    logic                wr_en;
    logic                rd_en;
    logic                unused_addr;

    assign unused_addr = ^i_mem_addr[NB_WIDTH-1:NB_ADDR];

    // Byte lanes a..a+3 wrap modulo the memory depth through the NB_ADDR-bit add.
    always_comb begin
        for (int i = 0; i < NB_BYTES; i++) begin
            addr[i] = i_mem_addr[NB_ADDR-1:0] + NB_ADDR'(i);
            raw_word[i*NB_DATA +: NB_DATA] = mem[addr[i]];
            byte_we[i] = (i == 0) || ((i == 1) && (i_BHW_CU[1:0] != BHW_BYTE)) || i_BHW_CU[1];
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_misaligned(i_BHW_CU[1:0], i_mem_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign wr_en = i_mem_write_CU && !misaligned;
    assign rd_en = i_mem_read_CU  && !misaligned;

    load_extend #(
        .NB_WIDTH (NB_WIDTH),
        .NB_DATA  (NB_DATA)
    ) u_load_extend (
        .raw_word (raw_word),
        .bhw      (i_BHW_CU),
        .ext_word (ext_word)
    );

    // Load samples pre-write contents, so same-cycle read/write is read-before-write.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
            o_read_data <= '0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < NB_BYTES; i++) begin
                    if (byte_we[i]) begin
                        mem[addr[i]] <= i_mem_data[i*NB_DATA +: NB_DATA];
                    end
                end
            end
            if (rd_en) begin
                o_read_data <= ext_word;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_misaligned <= 1'b0;
        end else if (i_mem_read_CU || i_mem_write_CU) begin
            o_misaligned <= misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected loads are queued when driven, compared when the result registers.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  bhw;
    logic [31:0] read_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_mem_addr     (mem_addr),
        .i_mem_data     (mem_data),
        .i_mem_read_CU  (mem_read),
        .i_mem_write_CU (mem_write),
        .i_BHW_CU       (bhw),
`ifdef MEM_ALIGN_CHECK_EN
        .o_misaligned   (misaligned),
`endif
        .o_read_data    (read_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic access(input bit wr, input bit rd, input logic [2:0] code,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp, input string tag);
        @(negedge clk);
        mem_write = wr;
        mem_read  = rd;
        bhw       = code;
        mem_addr  = addr;
        mem_data  = data;
        if (rd) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (rd) begin
            if (exp_q.size() == 0) check({tag, "_queue"}, 32'd1, 32'd0);
            else                   check(tag, read_data, exp_q.pop_front());
        end
    endtask

    task automatic store(input logic [2:0] code, input logic [31:0] addr, input logic [31:0] data);
        access(1'b1, 1'b0, code, addr, data, 32'h0, "st");
    endtask

    task automatic load(input logic [2:0] code, input logic [31:0] addr,
                        input logic [31:0] exp, input string tag);
        access(1'b0, 1'b1, code, addr, 32'h0, exp, tag);
    endtask

    initial begin
        rst_n     = 1'b1;
        mem_addr  = '0;
        mem_data  = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        bhw       = 3'b011;
        #3 rst_n  = 1'b0;
        #1 check("reset_rd", read_data, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        store(3'b011, 32'h010, 32'h12345678);
        load (3'b011, 32'h010, 32'h12345678, "lw");
        load (3'b111, 32'h010, 32'h12345678, "lwu");

        store(3'b000, 32'h011, 32'h000000AB);
        load (3'b000, 32'h011, 32'hFFFFFFAB, "lb_neg");
        load (3'b100, 32'h011, 32'h000000AB, "lbu");
        load (3'b011, 32'h010, 32'h1234AB78, "lw_after_sb");

        store(3'b001, 32'h012, 32'h0000CDEF);
        load (3'b001, 32'h012, 32'hFFFFCDEF, "lh_neg");
        load (3'b101, 32'h012, 32'h0000CDEF, "lhu");
        store(3'b001, 32'h012, 32'h00001234);
        load (3'b001, 32'h012, 32'h00001234, "lh_pos");
        load (3'b011, 32'h210, 32'h1234AB78, "lw_hi_addr_ignored");

        store(3'b011, 32'h000, 32'h00000001);
        load (3'b011, 32'h000, 32'h00000001, "lw_zero");
        store(3'b011, 32'h1FF, 32'hFFFFFFFF);
        load (3'b011, 32'h1FF, 32'hFFFFFFFF, "lw_wrap");
        load (3'b000, 32'h000, 32'hFFFFFFFF, "lb_wrap");
        load (3'b011, 32'h000, 32'h00FFFFFF, "lw_wrap_partial");

        store(3'b100, 32'h030, 32'h00000080);
        load (3'b000, 32'h030, 32'hFFFFFF80, "sb_unsigned_code");
        store(3'b010, 32'h040, 32'hA5A55A5A);
        load (3'b010, 32'h040, 32'hA5A55A5A, "code10_word");

        access(1'b1, 1'b1, 3'b011, 32'h020, 32'hDEADBEEF, 32'h0, "rd_before_wr");
        load (3'b011, 32'h020, 32'hDEADBEEF, "wr_committed");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_addr = 32'h010;
            @(posedge clk);
            #1 check("hold", read_data, 32'hDEADBEEF);
        end

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", read_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        load (3'b011, 32'h010, 32'h0, "mem_cleared_010");
        load (3'b011, 32'h020, 32'h0, "mem_cleared_020");

`ifdef MEM_ALIGN_CHECK_EN
        store(3'b011, 32'h010, 32'h11223344);
        check("mis_aligned_sw", {31'h0, misaligned}, 32'h0);
        store(3'b011, 32'h011, 32'hFFFFFFFF);
        check("mis_sw", {31'h0, misaligned}, 32'h1);
        load (3'b011, 32'h010, 32'h11223344, "mis_sw_suppressed");
        check("mis_cleared", {31'h0, misaligned}, 32'h0);
        load (3'b001, 32'h013, 32'h11223344, "mis_lh_hold");
        check("mis_lh", {31'h0, misaligned}, 32'h1);
`endif

        if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
